// File: rtl/seg7_pkg.sv
// Shared glyph table, segment indices and leading-zero helper for the
// seven-segment scan driver.
package seg7_pkg;

  localparam int MAX_DIGITS = 16;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef logic [0:6] glyph_t;

  // Active-high a..g, segment a in bit 0.
  localparam glyph_t GLYPH_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Bit i set when nibble i and every nibble above it (up to digits-1) are
  // zero; bit 0 and bits at or above digits are always clear.
  function automatic logic [MAX_DIGITS-1:0] lzb_mask(
    input logic [4*MAX_DIGITS-1:0] value,
    input int                      digits
  );
    logic above_zero;
    above_zero = 1'b1;
    lzb_mask   = '0;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < digits) begin
        above_zero  = above_zero && (value[4*i +: 4] == 4'h0);
        lzb_mask[i] = above_zero;
      end else begin
        lzb_mask[i] = 1'b0;
      end
    end
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational hex-nibble to seven-segment glyph lookup.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [0:6] segs
);

  // Table lookup on the nibble currently being scanned.
  always_comb begin
    segs = GLYPH_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with frame-synchronous value updates,
// optional leading-zero blanking and per-slot anode dead time.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 16,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit LZB        = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [0:7]            d,
  output logic                  frame_done
);

  localparam int PCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PCW-1:0] PC_LAST  = PCW'(CLK_DIV - 1);
  localparam logic [PCW-1:0] PC_PRE   = PCW'(CLK_DIV - 2);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);

  logic [PCW-1:0]          pc_r;
  logic [IW-1:0]           idx_r;
  logic [4*DIGITS-1:0]     pend_value_r;
  logic [DIGITS-1:0]       pend_dp_r;
  logic [DIGITS-1:0]       pend_blank_r;
  logic [4*DIGITS-1:0]     act_value_r;
  logic [DIGITS-1:0]       act_dp_r;
  logic [DIGITS-1:0]       act_blank_r;
  logic [DIGITS-1:0]       an_r;
  logic [0:7]              d_r;
  logic                    frame_done_r;

  logic                    pc_last_s;
  logic                    boundary_s;
  logic                    pre_boundary_s;
  logic [4*MAX_DIGITS-1:0] value_ext_s;
  logic [MAX_DIGITS-1:0]   lzb_full_s;
  logic [3:0]              cur_nib_s;
  logic                    cur_dp_s;
  logic                    cur_blank_s;
  logic                    cur_lzb_s;
  logic [DIGITS-1:0]       onehot_s;
  logic [0:6]              glyph_s;
  logic                    lit_s;
  logic [0:7]              d_raw_s;
  logic [DIGITS-1:0]       an_nxt_s;
  logic [0:7]              d_nxt_s;

  assign pc_last_s      = (pc_r == PC_LAST);
  assign boundary_s     = pc_last_s && (idx_r == IDX_LAST);
  // frame_done is registered, so decode the cycle just before the boundary.
  assign pre_boundary_s = (pc_r == PC_PRE) && (idx_r == IDX_LAST);

  // Prescaler and digit index counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r  <= '0;
      idx_r <= '0;
    end else if (pc_last_s) begin
      pc_r  <= '0;
      idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
    end else begin
      pc_r  <= pc_r + PCW'(1);
    end
  end

  // Pending register set, written by the load strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_value_r <= '0;
      pend_dp_r    <= '0;
      pend_blank_r <= '0;
    end else if (load) begin
      pend_value_r <= value;
      pend_dp_r    <= dp_in;
      pend_blank_r <= blank_in;
    end
  end

  // Active register set; takes the pre-edge pending contents at the boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_value_r <= '0;
      act_dp_r    <= '0;
      act_blank_r <= '0;
    end else if (boundary_s) begin
      act_value_r <= pend_value_r;
      act_dp_r    <= pend_dp_r;
      act_blank_r <= pend_blank_r;
    end
  end

  // Leading-zero mask over the active value, widened for the package helper.
  always_comb begin
    value_ext_s                 = '0;
    value_ext_s[4*DIGITS-1:0]   = act_value_r;
    lzb_full_s                  = lzb_mask(value_ext_s, DIGITS);
  end

  // Select the active fields of the digit under scan.
  always_comb begin
    cur_nib_s   = 4'h0;
    cur_dp_s    = 1'b0;
    cur_blank_s = 1'b0;
    cur_lzb_s   = 1'b0;
    onehot_s    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      onehot_s[i] = (idx_r == IW'(i));
      cur_nib_s   = cur_nib_s | (act_value_r[4*i +: 4] & {4{onehot_s[i]}});
      cur_dp_s    = cur_dp_s | (act_dp_r[i] & onehot_s[i]);
      cur_blank_s = cur_blank_s | (act_blank_r[i] & onehot_s[i]);
    end
    for (int i = 0; i < MAX_DIGITS; i++) begin
      cur_lzb_s = cur_lzb_s | (lzb_full_s[i] & (int'(idx_r) == i));
    end
  end

  seg7_glyph_rom u_glyph_rom (
    .nibble (cur_nib_s),
    .segs   (glyph_s)
  );

  // Next anode/segment pattern, polarity applied last.
  always_comb begin
    lit_s                   = (int'(pc_r) >= BLANK_CYC) && !cur_blank_s && !(LZB && cur_lzb_s);
    d_raw_s                 = 8'h00;
    d_raw_s[SEG_A:SEG_G]    = glyph_s;
    d_raw_s[SEG_DP]         = cur_dp_s;
    if (lit_s) begin
      an_nxt_s = onehot_s ^ {DIGITS{ACTIVE_LOW}};
      d_nxt_s  = d_raw_s ^ {8{ACTIVE_LOW}};
    end else begin
      an_nxt_s = {DIGITS{ACTIVE_LOW}};
      d_nxt_s  = {8{ACTIVE_LOW}};
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r         <= {DIGITS{ACTIVE_LOW}};
      d_r          <= {8{ACTIVE_LOW}};
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_nxt_s;
      d_r          <= d_nxt_s;
      frame_done_r <= pre_boundary_s;
    end
  end

  assign an         = an_r;
  assign d          = d_r;
  assign frame_done = frame_done_r;

endmodule
